// File: rtl/ansi_pkg.sv
// ---------------------------------------------------------------------------
// ansi_pkg
// Shared definitions for the ANSI stream decoder: command op codes, the
// byte values the parser reacts to, the parser state encoding and a small
// byte-classification helper.
// No ports (package).
// ---------------------------------------------------------------------------
package ansi_pkg;

    typedef enum logic [2:0] {
        OP_PUTC    = 3'd0,
        OP_GOTO    = 3'd1,
        OP_CLEAR   = 3'd2,
        OP_SGR     = 3'd3,
        OP_NEWLINE = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_ESC    = 2'd1,
        ST_CSI    = 2'd2
    } state_e;

    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_ESC    = 8'h1B;
    localparam logic [7:0] CH_LBRACK = 8'h5B;
    localparam logic [7:0] CH_SEMI   = 8'h3B;
    localparam logic [7:0] CH_H      = 8'h48;
    localparam logic [7:0] CH_J      = 8'h4A;
    localparam logic [7:0] CH_M      = 8'h6D;
    localparam logic [7:0] CH_DEL    = 8'h7F;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    // CSI final bytes live in 0x40..0x7E.
    function automatic logic is_final(input logic [7:0] b);
        return (b >= 8'h40) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/ansi_stream_decoder_if.sv
// ---------------------------------------------------------------------------
// ansi_stream_decoder_if
// Byte-in / command-out bundle of the ANSI stream decoder.
//   in_valid/in_byte/in_ready         : input byte stream handshake
//   cmd_valid/cmd_ready               : command handshake
//   cmd_op/cmd_arg0/cmd_arg1/cmd_nparam : decoded command
//   err                               : one-cycle malformed-sequence pulse
// Modports:
//   master : the environment (byte producer and command consumer)
//   slave  : the decoder
// ---------------------------------------------------------------------------
interface ansi_stream_decoder_if #(
    parameter int PARAM_W = 8
);
    logic               in_valid;
    logic [7:0]         in_byte;
    logic               in_ready;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_op;
    logic [PARAM_W-1:0] cmd_arg0;
    logic [PARAM_W-1:0] cmd_arg1;
    logic [1:0]         cmd_nparam;
    logic               err;

    modport master (
        output in_valid, in_byte, cmd_ready,
        input  in_ready, cmd_valid, cmd_op, cmd_arg0, cmd_arg1, cmd_nparam, err
    );

    modport slave (
        input  in_valid, in_byte, cmd_ready,
        output in_ready, cmd_valid, cmd_op, cmd_arg0, cmd_arg1, cmd_nparam, err
    );
endinterface

// File: rtl/ansi_stream_decoder_csi_param_acc.sv
// ---------------------------------------------------------------------------
// csi_param_acc
// One decimal CSI parameter accumulator. Each digit strobe computes
// value*10 + digit with four bits of headroom, then saturates to
// 2**PARAM_W-1. clr zeroes the value at the start of a new sequence.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear
//   dig_stb    : accumulate digit this cycle
//   digit      : decimal digit 0..9
//   value      : current parameter value
// ---------------------------------------------------------------------------
module csi_param_acc #(
    parameter int PARAM_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               dig_stb,
    input  logic [3:0]         digit,
    output logic [PARAM_W-1:0] value
);

    localparam int ACC_W = PARAM_W + 4;

    function automatic logic [PARAM_W-1:0] sat_param(input logic [ACC_W-1:0] x);
        if (x > {4'b0000, {PARAM_W{1'b1}}}) begin
            return {PARAM_W{1'b1}};
        end
        return x[PARAM_W-1:0];
    endfunction

    logic [ACC_W-1:0] acc_next;

    // (2**W-1)*10 + 9 < 16*2**W, so the widened product never wraps.
    assign acc_next = ({4'b0000, value} * ACC_W'(10)) + {{PARAM_W{1'b0}}, digit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (dig_stb) begin
            value <= sat_param(acc_next);
        end
    end

endmodule

// File: rtl/ansi_stream_decoder.sv
// ---------------------------------------------------------------------------
// ansi_stream_decoder
// Parses an ANSI terminal byte stream into screen commands (PUTC, GOTO,
// CLEAR, SGR, NEWLINE). One byte is accepted per handshake; a byte that
// completes a command loads the command register, which holds until the
// consumer takes it. While a command is held no new byte is accepted.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : ansi_stream_decoder_if.slave (byte stream in, command out, err)
// MAX_PARAMS must be at least 2 (GOTO/SGR read two parameters).
// ---------------------------------------------------------------------------
module ansi_stream_decoder
    import ansi_pkg::*;
#(
    parameter int MAX_PARAMS = 2,
    parameter int PARAM_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ansi_stream_decoder_if.slave   bus
);

    state_e             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic               accept;
    logic               acc_clr;
    logic [MAX_PARAMS-1:0] dig_stb;
    logic [PARAM_W-1:0] p [MAX_PARAMS];

    logic               cmd_load;
    logic [2:0]         op_d;
    logic [PARAM_W-1:0] arg0_d, arg1_d;
    logic [1:0]         nparam_d;
    logic               err_d;

    logic               cmd_valid_q;
    logic [2:0]         cmd_op_q;
    logic [PARAM_W-1:0] cmd_arg0_q, cmd_arg1_q;
    logic [1:0]         cmd_nparam_q;
    logic               err_q;

    assign bus.in_ready   = ~cmd_valid_q;
    assign accept         = bus.in_valid & ~cmd_valid_q;
    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_op     = cmd_op_q;
    assign bus.cmd_arg0   = cmd_arg0_q;
    assign bus.cmd_arg1   = cmd_arg1_q;
    assign bus.cmd_nparam = cmd_nparam_q;
    assign bus.err        = err_q;

    // Only the parameter currently addressed by idx takes digits; once idx
    // runs past the retained parameters, no strobe fires and digits vanish.
    for (genvar i = 0; i < MAX_PARAMS; i++) begin : g_param
        assign dig_stb[i] = accept && (state_q == ST_CSI) && is_digit(bus.in_byte)
                            && (idx_q == 2'(i));

        csi_param_acc #(
            .PARAM_W (PARAM_W)
        ) u_acc (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (acc_clr),
            .dig_stb (dig_stb[i]),
            .digit   (bus.in_byte[3:0]),
            .value   (p[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_clr  = 1'b0;
        cmd_load = 1'b0;
        op_d     = OP_PUTC;
        arg0_d   = '0;
        arg1_d   = '0;
        nparam_d = 2'd0;
        err_d    = 1'b0;

        if (accept) begin
            unique case (state_q)
                ST_GROUND: begin
                    if (bus.in_byte == CH_ESC) begin
                        state_d = ST_ESC;
                    end else if (bus.in_byte == CH_LF) begin
                        cmd_load = 1'b1;
                        op_d     = OP_NEWLINE;
                    end else if ((bus.in_byte >= 8'h20) && (bus.in_byte != CH_DEL)) begin
                        // Printable ASCII and raw UTF-8 bytes both become PUTC.
                        cmd_load = 1'b1;
                        op_d     = OP_PUTC;
                        arg0_d   = PARAM_W'(bus.in_byte);
                    end
                end

                ST_ESC: begin
                    if (bus.in_byte == CH_LBRACK) begin
                        state_d = ST_CSI;
                        acc_clr = 1'b1;
                        idx_d   = 2'd0;
                    end else if (bus.in_byte == CH_ESC) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_GROUND;
                    end
                end

                ST_CSI: begin
                    if (is_digit(bus.in_byte)) begin
                        state_d = ST_CSI;
                    end else if (bus.in_byte == CH_SEMI) begin
                        idx_d = (idx_q == 2'd3) ? 2'd3 : idx_q + 2'd1;
                    end else if (is_final(bus.in_byte)) begin
                        state_d = ST_GROUND;
                        if (bus.in_byte == CH_H) begin
                            cmd_load = 1'b1;
                            op_d     = OP_GOTO;
                            arg0_d   = (p[0] == '0) ? PARAM_W'(1) : p[0];
                            arg1_d   = (p[1] == '0) ? PARAM_W'(1) : p[1];
                        end else if (bus.in_byte == CH_J) begin
                            if (p[0] == PARAM_W'(2)) begin
                                cmd_load = 1'b1;
                                op_d     = OP_CLEAR;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else if (bus.in_byte == CH_M) begin
                            cmd_load = 1'b1;
                            op_d     = OP_SGR;
                            arg0_d   = p[0];
                            arg1_d   = p[1];
                            // Fields seen = separators + 1, capped at the retained count.
                            if (int'(idx_q) >= MAX_PARAMS - 1) begin
                                nparam_d = 2'(MAX_PARAMS);
                            end else begin
                                nparam_d = idx_q + 2'd1;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (bus.in_byte == CH_ESC) begin
                        err_d   = 1'b1;
                        state_d = ST_ESC;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_GROUND;
                    end
                end

                default: begin
                    state_d = ST_GROUND;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_GROUND;
            idx_q   <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    // Command register: loads on a completing byte, clears on consumption.
    // in_ready is low while valid, so load and consume never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid_q  <= 1'b0;
            cmd_op_q     <= 3'd0;
            cmd_arg0_q   <= '0;
            cmd_arg1_q   <= '0;
            cmd_nparam_q <= 2'd0;
        end else if (cmd_load) begin
            cmd_valid_q  <= 1'b1;
            cmd_op_q     <= op_d;
            cmd_arg0_q   <= arg0_d;
            cmd_arg1_q   <= arg1_d;
            cmd_nparam_q <= nparam_d;
        end else if (cmd_valid_q && bus.cmd_ready) begin
            cmd_valid_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ansi_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_ansi_stream_decoder
// Directed and randomized stimulus for ansi_stream_decoder. Random streams
// are built from whole tokens and checked against a scanning parser model.
// ---------------------------------------------------------------------------
module tb_ansi_stream_decoder;

    localparam int PW = 8;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a0;
        logic [7:0] a1;
        logic [1:0] np;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ansi_stream_decoder_if #(.PARAM_W(PW)) bus_if ();

    ansi_stream_decoder #(
        .MAX_PARAMS (2),
        .PARAM_W    (PW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   rdy_mode = 0;    // 0 always ready, 1 random, 2 held low
    int   gap_mode = 0;    // 0 back-to-back bytes, 1 random idle gaps
    int   err_seen = 0;
    int   err_base = 0;
    int   exp_err  = 0;
    cmd_t got_q[$];
    cmd_t exp_q[$];
    logic [7:0] stim_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [2:0] op, input int a0, input int a1, input int np);
        cmd_t c;
        c.op = op; c.a0 = 8'(a0); c.a1 = 8'(a1); c.np = 2'(np);
        return c;
    endfunction

    // Consumer side: cmd_ready changes just after the edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus_if.cmd_ready = 1'b1;
            1:       bus_if.cmd_ready = 1'($urandom_range(0, 1));
            default: bus_if.cmd_ready = 1'b0;
        endcase
    end

    // A command seen valid & ready here is consumed at the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.err) err_seen++;
            if (bus_if.cmd_valid && bus_if.cmd_ready)
                got_q.push_back(mk(bus_if.cmd_op, int'(bus_if.cmd_arg0),
                                   int'(bus_if.cmd_arg1), int'(bus_if.cmd_nparam)));
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit acc = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in_byte  = b;
        for (int t = 0; t < 400 && !acc; t++) begin
            @(negedge clk);
            acc = bus_if.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        bus_if.in_valid = 1'b0;
        if (gap_mode == 1) repeat ($urandom_range(0, 2)) @(posedge clk);
        #0;
    endtask

    task automatic send_all();
        for (int k = 0; k < stim_q.size(); k++) send_byte(stim_q[k]);
        stim_q.delete();
    endtask

    task automatic drain();
        int idle = 0;
        for (int t = 0; t < 600 && idle < 3; t++) begin
            @(negedge clk);
            idle = bus_if.cmd_valid ? 0 : idle + 1;
        end
        if (idle < 3) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic add_str(input string s);
        for (int k = 0; k < s.len(); k++) stim_q.push_back(s[k]);
    endtask

    task automatic add_csi(input string s);
        stim_q.push_back(8'h1B);
        add_str({"[", s});
    endtask

    task automatic compare(input string tag);
        int n;
        chk({tag, "_ncmd"}, got_q.size(), exp_q.size());
        chk({tag, "_nerr"}, err_seen - err_base, exp_err);
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_op%0d", tag, k), got_q[k].op, exp_q[k].op);
            if (exp_q[k].op inside {3'd0, 3'd1, 3'd3})
                chk($sformatf("%s_a0_%0d", tag, k), got_q[k].a0, exp_q[k].a0);
            if (exp_q[k].op inside {3'd1, 3'd3})
                chk($sformatf("%s_a1_%0d", tag, k), got_q[k].a1, exp_q[k].a1);
            chk($sformatf("%s_np%0d", tag, k), got_q[k].np, exp_q[k].np);
        end
        got_q.delete();
        exp_q.delete();
        exp_err  = 0;
        err_base = err_seen;
    endtask

    function automatic int sat255(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    // Scanning parser over a whole byte list. Each escape is read to its end
    // with look-ahead loops; field values are plain integers.
    function automatic void model();
        int i = 0;
        int n = stim_q.size();
        logic [7:0] b;
        bit in_esc, in_csi;
        int f0, f1, nf;
        while (i < n) begin
            b = stim_q[i]; i++;
            if (b == 8'h1B) begin
                in_esc = 1;
                while (in_esc && i < n) begin
                    b = stim_q[i]; i++;
                    if (b == 8'h1B) exp_err++;
                    else if (b != 8'h5B) begin exp_err++; in_esc = 0; end
                    else begin
                        in_esc = 0; in_csi = 1; f0 = 0; f1 = 0; nf = 1;
                        while (in_csi && i < n) begin
                            b = stim_q[i]; i++;
                            if (b >= 8'h30 && b <= 8'h39) begin
                                if (nf == 1) f0 = sat255(f0 * 10 + int'(b) - 48);
                                else if (nf == 2) f1 = sat255(f1 * 10 + int'(b) - 48);
                            end else if (b == 8'h3B) nf++;
                            else begin
                                in_csi = 0;
                                if (b == 8'h48)
                                    exp_q.push_back(mk(3'd1, (f0 == 0) ? 1 : f0, (f1 == 0) ? 1 : f1, 0));
                                else if (b == 8'h4A) begin
                                    if (f0 == 2) exp_q.push_back(mk(3'd2, 0, 0, 0));
                                    else exp_err++;
                                end else if (b == 8'h6D)
                                    exp_q.push_back(mk(3'd3, f0, f1, (nf > 2) ? 2 : nf));
                                else if (b == 8'h1B) begin exp_err++; in_esc = 1; end
                                else exp_err++;
                            end
                        end
                    end
                end
            end else if (b == 8'h0A) exp_q.push_back(mk(3'd4, 0, 0, 0));
            else if (b >= 8'h20 && b != 8'h7F) exp_q.push_back(mk(3'd0, int'(b), 0, 0));
        end
    endfunction

    task automatic add_token();
        int   kind = $urandom_range(0, 8);
        int   nfld;
        logic [7:0] b;
        case (kind)
            0: stim_q.push_back(8'($urandom_range(8'h20, 8'h7E)));
            1: stim_q.push_back(8'($urandom_range(8'h80, 8'hFF)));
            2: stim_q.push_back(8'h0A);
            3: begin
                b = 8'($urandom_range(0, 8'h1F));
                if (b == 8'h0A || b == 8'h1B) b = 8'h7F;
                stim_q.push_back(b);
            end
            4: begin
                stim_q.push_back(8'h1B);
                stim_q.push_back(8'h5B);
                nfld = $urandom_range(0, 3);
                for (int f = 0; f < nfld; f++) begin
                    if (f > 0) stim_q.push_back(8'h3B);
                    if ($urandom_range(0, 4) != 0) add_str($sformatf("%0d", $urandom_range(0, 400)));
                end
                case ($urandom_range(0, 4))
                    0: stim_q.push_back(8'h48);
                    1: stim_q.push_back(8'h4A);
                    2, 3: stim_q.push_back(8'h6D);
                    default: stim_q.push_back(8'($urandom_range(8'h40, 8'h7E)));
                endcase
            end
            5: begin
                b = 8'($urandom_range(8'h20, 8'h7E));
                if (b == 8'h5B) b = 8'h41;
                stim_q.push_back(8'h1B);
                stim_q.push_back(b);
            end
            6: begin stim_q.push_back(8'h1B); add_csi("2J"); end
            7: begin add_csi("3"); add_csi("1m"); end
            default: begin
                add_csi("4");
                stim_q.push_back(($urandom_range(0, 1) == 1) ? 8'h3A : 8'($urandom_range(8'h20, 8'h2F)));
            end
        endcase
    endtask

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.in_byte   = 8'h00;
        bus_if.cmd_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd_valid", bus_if.cmd_valid, 0);
        chk("rst_in_ready", bus_if.in_ready, 1);
        chk("rst_err", bus_if.err, 0);
        chk("rst_op", bus_if.cmd_op, 0);
        chk("rst_arg0", bus_if.cmd_arg0, 0);
        chk("rst_arg1", bus_if.cmd_arg1, 0);
        chk("rst_nparam", bus_if.cmd_nparam, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        add_csi("12;40H");
        send_all(); drain();
        exp_q.push_back(mk(3'd1, 12, 40, 0));
        compare("goto");

        add_csi("2J"); add_csi("H");
        send_all(); drain();
        exp_q.push_back(mk(3'd2, 0, 0, 0));
        exp_q.push_back(mk(3'd1, 1, 1, 0));
        compare("clear_home");

        add_csi("1;33m"); add_csi("0m");
        send_all(); drain();
        exp_q.push_back(mk(3'd3, 1, 33, 2));
        exp_q.push_back(mk(3'd3, 0, 0, 1));
        compare("sgr");

        add_csi("300;7;9H"); add_csi("5X");
        send_all(); drain();
        exp_q.push_back(mk(3'd1, 255, 7, 0));
        exp_err = 1;
        compare("sat_bad_final");

        stim_q.push_back(8'h1B); add_csi("m");
        stim_q.push_back(8'h1B); add_str("ab");
        add_csi("3J");
        stim_q.push_back(8'h07); stim_q.push_back(8'h0A); stim_q.push_back(8'hC3);
        send_all(); drain();
        exp_q.push_back(mk(3'd3, 0, 0, 1));
        exp_q.push_back(mk(3'd0, 8'h62, 0, 0));
        exp_q.push_back(mk(3'd4, 0, 0, 0));
        exp_q.push_back(mk(3'd0, 8'hC3, 0, 0));
        exp_err = 3;
        compare("misc");

        // Backpressure: consumer stalls while three PUTCs are offered
        rdy_mode = 2;
        add_str("<@>");
        fork
            begin send_all(); drain(); end
            begin
                repeat (3) @(negedge clk);
                for (int k = 0; k < 5; k++) begin
                    chk("bp_in_ready", bus_if.in_ready, 0);
                    chk("bp_cmd_valid", bus_if.cmd_valid, 1);
                    @(negedge clk);
                end
                rdy_mode = 0;
            end
        join
        exp_q.push_back(mk(3'd0, 8'h3C, 0, 0));
        exp_q.push_back(mk(3'd0, 8'h40, 0, 0));
        exp_q.push_back(mk(3'd0, 8'h3E, 0, 0));
        compare("backpressure");

        // Reset drops a pending command and a partial sequence
        rdy_mode = 2;
        add_str("Q"); send_all();
        @(negedge clk);
        chk("pend_valid", bus_if.cmd_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_drop_valid", bus_if.cmd_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk); #1;
        add_csi("4"); send_all();
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_mid_valid", bus_if.cmd_valid, 0);
            chk("rst_mid_err", bus_if.err, 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        add_str("A"); send_all(); drain();
        exp_q.push_back(mk(3'd0, 8'h41, 0, 0));
        compare("reset_mid");

        // Randomized token streams with random gaps and consumer stalls
        for (int it = 0; it < 30; it++) begin
            rdy_mode = $urandom_range(0, 1);
            gap_mode = $urandom_range(0, 1);
            for (int t = 0; t < 10; t++) add_token();
            model();
            send_all(); drain();
            compare($sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
